frac_pps_gen: RTL and testbench
===============================

Name: frac_pps_gen

Overview:
- Multi-channel fractional-divide timing generator built from N independent phase accumulators (NCOs).
- Each channel produces three outputs: a square wave (accumulator MSB), a programmable-duty PWM output, and a one-cycle pulse on every accumulator wrap.
- Per-channel increment and duty are runtime-writable through a simple register write port. A global sync input zeroes all phases together.
- Sits between the board clock and LED/timing consumers; it is the general-purpose timing source for downstream blocks.

Parameters:
- NCH, 4, number of channels (1..16)
- CHW, 2, width of channel select; equals clog2(NCH), minimum 1
- WIDTH, 32, accumulator, increment and duty width in bits (4..32)
- DEFAULT_INCR, 358, reset increment for all channels; 2^32/12 MHz, giving about 1 Hz at 12 MHz
- DEFAULT_DUTY, 2^(WIDTH-1), reset duty threshold for all channels (50%)

Ports:
- i_clk  in  1  system clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_wr  in  1  register write strobe, single cycle, no backpressure
- i_wr_sel  in  1  write target: 0 = increment register, 1 = duty register
- i_wr_ch  in  CHW  channel index for the write
- i_wr_data  in  WIDTH  write data
- i_sync  in  1  zero every channel's phase accumulator
- i_en  in  NCH  per-channel enable (bit c controls channel c)
- o_led  out  NCH  bit c = phase[c][WIDTH-1]
- o_pwm  out  NCH  bit c = (phase[c] < duty[c]), unsigned compare
- o_pps  out  NCH  bit c = one-cycle wrap pulse

Behaviour:
- Per channel c, state: phase[c], incr[c], duty[c], each WIDTH bits. All updates on posedge i_clk.
- Reset (highest priority) sets:
  - phase = 0, incr = DEFAULT_INCR, duty = DEFAULT_DUTY, o_pps = 0.
  - Hence o_led = 0 and o_pwm = 1 after reset, since 0 < DEFAULT_DUTY. If DEFAULT_DUTY = 0, o_pwm = 0.
- Reset mid-operation discards pending writes and sync in that cycle. Channels restart in phase lock on the cycle after reset deasserts.
- Accumulate, applied when i_en[c] = 1 and i_sync = 0:
  - {carry, phase[c]} <= phase[c] + incr[c], WIDTH+1-bit sum, modulo 2^WIDTH.
  - o_pps[c] <= carry.
  - o_pps is therefore high in exactly the cycle where phase holds its post-wrap value.
- Disabled (i_en[c] = 0, no sync): phase holds, o_pps[c] <= 0.
- Sync (i_sync = 1): every phase <= 0 and every o_pps <= 0, regardless of i_en. Sync does not generate a pulse.
- Write (i_wr = 1):
  - The target register of channel i_wr_ch is loaded with i_wr_data at the edge.
  - A new increment is first used by the addition at the following edge. The same-edge addition uses the old increment.
  - A new duty affects o_pwm from the cycle after the write.
  - The phase is never disturbed by a write.
  - Writes with i_wr_ch >= NCH are ignored.
  - Writes are honoured in the same cycle as i_sync or i_en = 0.
- o_led and o_pwm are decoded from registered state only, with no additional latency and no glitching paths from inputs.
- Boundary rules:
  - incr = 0: phase frozen, no pulses.
  - duty = 0: o_pwm constantly 0.
  - duty = 2^WIDTH-1: o_pwm low only when phase = all-ones.
  - incr >= 2^(WIDTH-1): wraps on consecutive cycles are legal, so o_pps may stay high continuously when incr = 2^WIDTH-1.
- Average pulse period per channel is 2^WIDTH/incr cycles. Individual periods are floor or ceil of that value.
- Channels are fully independent apart from the shared sync and reset.

Test Plan:
- Params NCH=2, WIDTH=8, DEFAULT_INCR=16, DEFAULT_DUTY=128; reset then i_en=2'b11 -> both o_pps pulse once every 16 cycles, first pulse 16 cycles after enable. o_led is 8 cycles high, 8 low. o_pwm is the inverse of o_led.
- Write incr=64 to ch1 mid-run -> ch1 pulse period becomes 4 from the next wrap. ch0 is unaffected, still period 16. ch1 phase continues from its value at the write.
- Write incr=3 to ch0; run 768 cycles -> exactly 9 pulses, with every interval 85 or 86 cycles.
- Write duty=64 to ch0 with incr=16 -> o_pwm[0] high 4 of every 16 cycles, aligned with phase values 0,16,32,48. Duty=0 -> o_pwm[0] stays 0.
- Assert i_sync for 1 cycle with channels at different phases, plus i_en[1]=0 -> next cycle both phases = 0 and no o_pps. Afterwards both channels are phase-locked.
- i_reset asserted mid-run, simultaneous with i_wr -> write dropped; all incr=16 and duty=128. Outputs o_pps=0, o_led=0, o_pwm=2'b11. Also write to ch index 2 with NCH=2 -> no state change.

Source files
------------

// File: rtl/frac_pps_gen.sv
// Multi-channel fractional-divide timing generator: one phase accumulator (NCO) per
// channel driving square-wave, PWM and wrap-pulse outputs, with runtime-writable incr/duty.

module frac_pps_lane #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RST_INCR = '0,
    parameter logic [WIDTH-1:0]  RST_DUTY = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sync,
    input  logic             i_en,
    input  logic             i_wr_incr,
    input  logic             i_wr_duty,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_led,
    output logic             o_pwm,
    output logic             o_pps
);
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] incr_q,  incr_d;
    logic [WIDTH-1:0] duty_q,  duty_d;
    logic             pps_q,   pps_d;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, phase_q} + {1'b0, incr_q};

    always_comb begin
        phase_d = phase_q;
        pps_d   = 1'b0;
        incr_d  = incr_q;
        duty_d  = duty_q;
        if (i_sync) begin
            phase_d = '0;
        end else if (i_en) begin
            {pps_d, phase_d} = sum;
        end
        // The accumulate above already used the old incr; the write lands for next edge.
        if (i_wr_incr) incr_d = i_wr_data;
        if (i_wr_duty) duty_d = i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= '0;
            incr_q  <= RST_INCR;
            duty_q  <= RST_DUTY;
            pps_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            incr_q  <= incr_d;
            duty_q  <= duty_d;
            pps_q   <= pps_d;
        end
    end

    assign o_led = phase_q[WIDTH-1];
    assign o_pwm = (phase_q < duty_q);
    assign o_pps = pps_q;
endmodule

module frac_pps_gen #(
    parameter int unsigned     NCH          = 4,
    parameter int unsigned     CHW          = 2,
    parameter int unsigned     WIDTH        = 32,
    parameter longint unsigned DEFAULT_INCR = 358,
    parameter longint unsigned DEFAULT_DUTY = 64'd1 << (WIDTH - 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr,
    input  logic             i_wr_sel,
    input  logic [CHW-1:0]   i_wr_ch,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_sync,
    input  logic [NCH-1:0]   i_en,
    output logic [NCH-1:0]   o_led,
    output logic [NCH-1:0]   o_pwm,
    output logic [NCH-1:0]   o_pps
);
    localparam logic [WIDTH-1:0] RST_INCR = WIDTH'(DEFAULT_INCR);
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(DEFAULT_DUTY);

    // Out-of-range channel indices match no lane, so those writes simply vanish.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic hit;
        assign hit = i_wr && (32'(i_wr_ch) == 32'(c));

        frac_pps_lane #(
            .WIDTH    (WIDTH),
            .RST_INCR (RST_INCR),
            .RST_DUTY (RST_DUTY)
        ) u_lane (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_sync    (i_sync),
            .i_en      (i_en[c]),
            .i_wr_incr (hit & ~i_wr_sel),
            .i_wr_duty (hit &  i_wr_sel),
            .i_wr_data (i_wr_data),
            .o_led     (o_led[c]),
            .o_pwm     (o_pwm[c]),
            .o_pps     (o_pps[c])
        );
    end
endmodule

// File: tb/tb_frac_pps_gen.sv
// Scoreboard bench for frac_pps_gen (NCH=2, WIDTH=8): driver updates an arithmetic
// reference model at each edge and queues expected outputs; a monitor compares them.

module tb_frac_pps_gen;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_wr = 1'b0;
    logic       i_wr_sel = 1'b0;
    logic [1:0] i_wr_ch = '0;
    logic [7:0] i_wr_data = '0;
    logic       i_sync = 1'b0;
    logic [1:0] i_en = '0;
    logic [1:0] o_led, o_pwm, o_pps;

    frac_pps_gen #(
        .NCH(2), .CHW(2), .WIDTH(8), .DEFAULT_INCR(16), .DEFAULT_DUTY(128)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_wr_sel(i_wr_sel),
        .i_wr_ch(i_wr_ch), .i_wr_data(i_wr_data), .i_sync(i_sync), .i_en(i_en),
        .o_led(o_led), .o_pwm(o_pwm), .o_pps(o_pps)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] led;
        logic [1:0] pwm;
        logic [1:0] pps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int unsigned m_phase[2];
    int unsigned m_incr[2];
    int unsigned m_duty[2];
    logic [1:0]  m_pps;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on phase, wrap = sum overflowed 2^8.
    task automatic model_edge(input logic rst, input logic wr, input logic sel,
                              input int unsigned ch, input int unsigned data,
                              input logic sync, input logic [1:0] en);
        exp_t e;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_phase[c] = 0; m_incr[c] = 16; m_duty[c] = 128;
            end
            m_pps = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int unsigned s;
                if (sync) begin
                    m_phase[c] = 0; m_pps[c] = 1'b0;
                end else if (en[c]) begin
                    s = m_phase[c] + m_incr[c];
                    m_pps[c] = (s >= 256);
                    m_phase[c] = s % 256;
                end else begin
                    m_pps[c] = 1'b0;
                end
            end
            if (wr && ch < 2) begin
                if (sel) m_duty[ch] = data;
                else     m_incr[ch] = data;
            end
        end
        for (int c = 0; c < 2; c++) begin
            e.led[c] = (m_phase[c] >= 128);
            e.pwm[c] = (m_phase[c] < m_duty[c]);
            e.pps[c] = m_pps[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic wr, input logic sel,
                        input int unsigned ch, input int unsigned data,
                        input logic sync, input logic [1:0] en);
        i_reset = rst; i_wr = wr; i_wr_sel = sel; i_wr_ch = ch[1:0];
        i_wr_data = data[7:0]; i_sync = sync; i_en = en;
        @(posedge i_clk);
        model_edge(rst, wr, sel, ch, data, sync, en);
        #1;
        i_reset = 1'b0; i_wr = 1'b0; i_sync = 1'b0;
    endtask

    task automatic run(input int n, input logic [1:0] en);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, en);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_led", o_led, e.led);
                chk("sb_pwm", o_pwm, e.pwm);
                chk("sb_pps", o_pps, e.pps);
            end
        end
    end

    initial begin : driver
        int first, cnt, last, wait_cyc;
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'b00);
        chk("rst_led", o_led, 0);
        chk("rst_pwm", o_pwm, 3);
        chk("rst_pps", o_pps, 0);

        // Default incr 16: first wrap lands on the 16th enabled edge.
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b11);
            if (o_pps[0] && first < 0) first = k;
        end
        chk("first_pps", first, 16);

        step(1'b0, 1'b1, 1'b0, 1, 64, 1'b0, 2'b11);
        run(40, 2'b11);

        // incr=3 from phase 0: 768 edges give 9 wraps spaced 85 or 86.
        step(1'b0, 1'b1, 1'b0, 0, 3, 1'b1, 2'b11);
        cnt = 0; last = -1;
        for (int k = 1; k <= 768; k++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b11);
            if (o_pps[0]) begin
                cnt++;
                if (last >= 0) chk("interval_ok", ((k - last) == 85 || (k - last) == 86), 1);
                last = k;
            end
        end
        chk("pulse_count", cnt, 9);

        step(1'b0, 1'b1, 1'b0, 0, 16, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b1, 0, 64, 1'b0, 2'b11);
        run(48, 2'b11);
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 2'b11);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b11);
            if (k % 5 == 0) chk("duty0_pwm", o_pwm[0], 0);
        end

        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 2'b01);
        chk("sync_pps", o_pps, 0);
        chk("sync_led", o_led, 0);
        run(30, 2'b11);

        for (int k = 0; k < 2000; k++) begin
            int unsigned d;
            case ($urandom_range(0, 5))
                0: d = 0;
                1: d = 255;
                2: d = 128;
                3: d = 1;
                default: d = $urandom_range(0, 255);
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), d, $urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)));
        end

        run(10, 2'b11);
        step(1'b1, 1'b1, 1'b0, 0, 200, 1'b1, 2'b11);
        chk("rst2_led", o_led, 0);
        chk("rst2_pwm", o_pwm, 3);
        chk("rst2_pps", o_pps, 0);
        step(1'b0, 1'b1, 1'b0, 2, 99, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 2'b11);
        run(40, 2'b11);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge i_clk);
            wait_cyc++;
        end
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
